if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the IF stage of the pipelined RISC-V core. It owns the PC and sequences single-outstanding requests to the instruction memory over a req/gnt/rvalid port. It delivers fetched instructions to the IF/ID register with a valid flag and honours IF/ID stall. Branch/jump redirects squash in-flight fetches.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, value of if_inst_o when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until granted
imem_addr  out  XLEN  fetch byte address (= pc)
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid (earliest: cycle after gnt)
imem_rdata  in  XLEN  fetched instruction
stall_i  in  1  IF/ID cannot accept this cycle
redirect_i  in  1  flush + load new PC (branch/jump from EX)
redirect_pc_i  in  XLEN  redirect target
if_valid_o  out  1  if_inst_o/if_pc_o hold a valid instruction
if_pc_o  out  XLEN  PC of delivered instruction
if_inst_o  out  XLEN  delivered instruction

Behaviour:
- Reset (rst_n low, async): state=BOOT, pc=RESET_PC, imem_req=0, if_valid_o=0, if_pc_o=0, if_inst_o=NOP_INST, hold buffer empty.
- imem_req=1 only in REQ; imem_addr=pc always. Exactly one request outstanding.
- States: BOOT, REQ, WAIT, HOLD, DROP.
- BOOT: unconditional -> REQ next cycle (first req one cycle after rst_n release).
- REQ: imem_req=1. redirect_i: pc<=redirect_pc_i, stay REQ (address may change before gnt). Else imem_gnt: -> WAIT. If redirect_i and imem_gnt same cycle: request counts as issued with old addr -> DROP, pc<=redirect_pc_i.
- WAIT: on imem_rvalid: if output slot free (if_valid_o==0 or stall_i==0): load if_inst_o<=imem_rdata, if_pc_o<=pc, if_valid_o<=1, pc<=pc+4, -> REQ. If slot occupied and stall_i=1: capture rdata/pc into hold buffer, pc<=pc+4, -> HOLD.
- HOLD: when stall_i=0: move buffer to output (valid=1) -> REQ. While stall_i=1 stay.
- DROP: wait for imem_rvalid, discard data, -> REQ. No output change from discarded data.
- Redirect has priority over stall and over rvalid in every state: if_valid_o<=0, if_inst_o<=NOP_INST, hold buffer discarded, pc<=redirect_pc_i with bits[1:0] forced to 0. WAIT+redirect -> DROP; WAIT+redirect+rvalid same cycle -> data discarded, -> REQ; HOLD+redirect -> REQ; DROP+redirect -> stay DROP.
- Output consumption: if_valid_o falls to 0 the cycle after a cycle with if_valid_o=1, stall_i=0, and no new load.
- Output holds stable (valid, pc, inst) while stall_i=1.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- imem_rvalid outside WAIT/DROP is ignored.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle) sustains 1 instruction per 2 cycles.

Test Plan:
- Reset: hold rst_n=0 with clk running -> imem_req=0, if_valid_o=0, if_inst_o=0x00000013. Release -> req asserts at addr 0x0 one cycle later.
- Stream, zero-wait memory returning addr-based data: fetches at 0x0,0x4,0x8 -> if_pc_o/if_inst_o sequence matches, if_valid_o pulses each response.
- Stall: stall_i=1 while a response arrives with output valid -> output unchanged, FSM in HOLD, no imem_req. Drop stall -> buffered instruction appears next cycle, then req to next PC.
- Redirect in WAIT to 0x100 -> late rvalid data discarded, if_valid_o=0, next imem_addr=0x100. Redirect coincident with rvalid -> same result.
- Redirect to 0x103 while stalled with HOLD full -> buffer flushed, if_valid_o=0, next request addr 0x100.
- Wrap + async reset: pc=0xFFFFFFFC fetch -> next addr 0x0. Assert rst_n mid-WAIT -> outputs immediately reset values, restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch controller: owns the PC, single-outstanding imem requests, IF/ID delivery
module if_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_hold_inst;
    logic [XLEN-1:0] r_hold_pc;
    logic            r_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_inst;

    logic            w_slot_free;
    logic            w_load_mem;
    logic            w_capture;
    logic            w_load_hold;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_slot_free   = !r_valid || !stall_i;
    assign w_load_mem    = (r_state == S_WAIT) && imem_rvalid && !redirect_i && w_slot_free;
    assign w_capture     = (r_state == S_WAIT) && imem_rvalid && !redirect_i && !w_slot_free;
    assign w_load_hold   = (r_state == S_HOLD) && !stall_i && !redirect_i;
    assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT: w_next_state = S_REQ;
            S_REQ: begin
                // A grant alongside a redirect still issued the old address, so its data must be drained
                if (imem_gnt) begin
                    w_next_state = redirect_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    w_next_state = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_next_state = w_slot_free ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_i || !stall_i) begin
                    w_next_state = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (r_state == S_REQ);
        imem_addr = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_hold_inst <= NOP_INST;
            r_hold_pc   <= '0;
        end else begin
            if (redirect_i) begin
                r_pc <= w_redirect_pc;
            end else if (w_load_mem || w_capture) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_capture) begin
                r_hold_inst <= imem_rdata;
                r_hold_pc   <= r_pc;
            end else if (redirect_i) begin
                r_hold_inst <= NOP_INST;
                r_hold_pc   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_out_pc   <= '0;
            r_out_inst <= NOP_INST;
        end else if (redirect_i) begin
            r_valid    <= 1'b0;
            r_out_inst <= NOP_INST;
        end else if (w_load_mem) begin
            r_valid    <= 1'b1;
            r_out_pc   <= r_pc;
            r_out_inst <= imem_rdata;
        end else if (w_load_hold) begin
            r_valid    <= 1'b1;
            r_out_pc   <= r_hold_pc;
            r_out_inst <= r_hold_inst;
        end else if (r_valid && !stall_i) begin
            r_valid    <= 1'b0;
            r_out_inst <= NOP_INST;
        end
    end

    assign if_valid_o = r_valid;
    assign if_pc_o    = r_out_pc;
    assign if_inst_o  = r_out_inst;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int n_checks;
    int n_fails;

    if_fetch_ctrl #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic st, input logic rdir, input logic [31:0] rpc);
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        imem_rdata    = rd;
        stall_i       = st;
        redirect_i    = rdir;
        redirect_pc_i = rpc;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        check_eq({tag, "_valid"}, 32'(if_valid_o), 32'(v));
        check_eq({tag, "_pc"},    if_pc_o, pc);
        check_eq({tag, "_inst"},  if_inst_o, inst);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] addr);
        check_eq({tag, "_req"},  32'(imem_req), 32'(r));
        check_eq({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // reset
        repeat (3) tick();
        check_req("rst", 1'b0, 32'h0);
        check_out("rst", 1'b0, 32'h0, NOP);
        rst_n = 1'b1;
        check_req("boot", 1'b0, 32'h0);
        tick();
        check_req("first_req", 1'b1, 32'h0);

        // zero-wait stream 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
            check_eq("strm_req_low", 32'(imem_req), 32'h0);
            if (i > 0) check_eq("strm_consumed", 32'(if_valid_o), 32'h0);
            drive(0, 1, 32'hDEAD_0000 | (i * 4), 0, 0, 0);
            tick();
            check_out("strm", 1'b1, 32'(i * 4), 32'hDEAD_0000 | (i * 4));
            check_req("strm_next", 1'b1, 32'((i + 1) * 4));
        end

        // stall: response lands in the hold buffer
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check_out("stall_wait", 1'b1, 32'h8, 32'hDEAD_0008);
        drive(0, 1, 32'hDEAD_000C, 1, 0, 0);
        tick();
        check_req("hold", 1'b0, 32'h10);
        check_out("hold", 1'b1, 32'h8, 32'hDEAD_0008);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        check_req("hold2", 1'b0, 32'h10);
        check_out("hold2", 1'b1, 32'h8, 32'hDEAD_0008);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_out("unhold", 1'b1, 32'hC, 32'hDEAD_000C);
        check_req("unhold", 1'b1, 32'h10);

        // redirect in WAIT, late rvalid discarded
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h100);
        tick();
        check_req("drop", 1'b0, 32'h100);
        drive(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
        tick();
        check_out("drop_done", 1'b0, 32'hC, NOP);
        check_req("drop_done", 1'b1, 32'h100);

        // redirect coincident with rvalid
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 32'hBAD1_BAD1, 0, 1, 32'h200);
        tick();
        check_out("rdir_rv", 1'b0, 32'hC, NOP);
        check_req("rdir_rv", 1'b1, 32'h200);

        // redirect to unaligned 0x103 while HOLD is full
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 32'hDEAD_0200, 0, 0, 0);
        tick();
        check_out("pre_hold", 1'b1, 32'h200, 32'hDEAD_0200);
        drive(1, 0, 0, 1, 0, 0);
        tick();
        drive(0, 1, 32'hDEAD_0204, 1, 0, 0);
        tick();
        check_req("hold_full", 1'b0, 32'h208);
        drive(0, 0, 0, 1, 1, 32'h103);
        tick();
        check_out("hold_flush", 1'b0, 32'h200, NOP);
        check_req("hold_flush", 1'b1, 32'h100);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_eq("no_ghost", 32'(if_valid_o), 32'h0);

        // redirect together with grant: old request drained via DROP
        drive(1, 0, 0, 0, 1, 32'h300);
        tick();
        check_req("gnt_rdir", 1'b0, 32'h300);
        drive(0, 1, 32'hBAD2_BAD2, 0, 0, 0);
        tick();
        check_out("gnt_rdir_done", 1'b0, 32'h200, NOP);
        check_req("gnt_rdir_done", 1'b1, 32'h300);

        // PC wrap
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 32'h1234_5678, 0, 0, 0);
        tick();
        check_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
        check_req("wrap", 1'b1, 32'h0);

        // async reset mid-WAIT
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check_out("pre_rst", 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 32'h0, NOP);
        check_req("async_rst", 1'b0, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_req("restart", 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
